// File: rtl/ep_pkg.sv
`default_nettype none
//============================================================================
// Module      : ep_pkg
// Description : Shared definitions for the boot ROM loader: loader state
//               encoding, SPI flash read opcodes and default image geometry
//               shared with the system ROM instance.
// Revision    : 1.0 - initial release
//============================================================================
package ep_pkg;

    // Loader states. ST_DUMMY is only reachable in fast-read builds.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } loader_state_t;

    // SPI flash opcodes
    localparam logic [7:0] SPI_READ      = 8'h03;
    localparam logic [7:0] SPI_FAST_READ = 8'h0B;

    // Default image geometry, shared with the ROM instance
    localparam int          DEFAULT_KB   = 64;
    localparam logic [23:0] DEFAULT_BASE = 24'h000000;
    localparam int          DEFAULT_DIV  = 1;

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
//============================================================================
// Module      : spi_clkgen
// Description : SPI mode-0 SCK generator. A half-period counter reloads with
//               DIV-1 and toggles SCK when it reaches zero. One-cycle enables
//               flag the cycle in which SCK is about to rise or fall, so the
//               consumer can sample/shift on the same clock edge that moves
//               SCK.
// Ports       : i_clock  system clock
//               i_reset  asynchronous active-low reset
//               i_en     run SCK; when low SCK is parked low and the counter
//                        is preloaded so the first half-period is full length
//               o_sck    SCK (idles low)
//               o_rise   SCK goes 0->1 at the end of this cycle
//               o_fall   SCK goes 1->0 at the end of this cycle
// Revision    : 1.0 - initial release
//============================================================================
module spi_clkgen #(
    parameter int DIV = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] C_RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       w_tick;

    always_comb begin
        w_tick = i_en && (cnt_q == 8'd0);
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        if (!i_en) begin
            cnt_d = C_RELOAD;
            sck_d = 1'b0;
        end else if (w_tick) begin
            cnt_d = C_RELOAD;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign o_sck  = sck_q;
    assign o_rise = w_tick && !sck_q;
    assign o_fall = w_tick &&  sck_q;

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
//============================================================================
// Module      : rom_loader
// Description : Boot-time loader that streams the ROM image out of SPI flash
//               (READ command, 24-bit address) and emits a byte-wide write
//               stream into the ROM backing RAM. busy holds the CPU in reset
//               until the last byte is written, then done goes sticky high.
// Build macro : ROM_LOADER_FAST_READ_EN - use FAST_READ (0x0B) with one dummy
//               byte after the address; otherwise plain READ (0x03).
// Ports       : clock  system clock (rising edge)
//               reset  asynchronous active-low reset
//               start  one-cycle pulse, accepted in IDLE or DONE
//               spiCs  flash chip select (active low)
//               spiCk  flash SCK, mode 0
//               spiDo  MOSI, MSB first
//               spiDi  MISO
//               a/d/w  ROM write address, data, one-cycle strobe
//               busy   load in progress
//               done   sticky load-complete flag
// Revision    : 1.0 - initial release
//============================================================================
module rom_loader
    import ep_pkg::*;
#(
    parameter int          KB   = DEFAULT_KB,
    parameter logic [23:0] BASE = DEFAULT_BASE,
    parameter int          DIV  = DEFAULT_DIV
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          spiCs,
    output logic                          spiCk,
    output logic                          spiDo,
    input  logic                          spiDi,
    output logic [$clog2(KB*1024)-1:0]    a,
    output logic [7:0]                    d,
    output logic                          w,
    output logic                          busy,
    output logic                          done
);

    localparam int            AW     = $clog2(KB*1024);
    localparam logic [AW-1:0] C_LAST = AW'(KB*1024 - 1);
`ifdef ROM_LOADER_FAST_READ_EN
    localparam logic [7:0]    C_CMD  = SPI_FAST_READ;
`else
    localparam logic [7:0]    C_CMD  = SPI_READ;
`endif

    loader_state_t state_q, state_d;
    logic [31:0]   sh_q, sh_d;      // outgoing command + address
    logic [7:0]    rx_q, rx_d;      // incoming data byte
    logic [4:0]    bit_q, bit_d;    // bits completed in the current phase
    logic [AW-1:0] a_q, a_d;
    logic [7:0]    d_q, d_d;
    logic          w_q, w_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_q, last_d;  // final byte strobed; stop SCK and finish

    logic          w_sck_en;
    logic          w_sck;
    logic          w_rise;
    logic          w_fall;

    // SCK runs whenever the flash is selected, except during the final
    // strobe cycle so that no stray edge follows the last byte.
    assign w_sck_en = (state_q != ST_IDLE) && (state_q != ST_DONE) && !last_q;

    spi_clkgen #(
        .DIV (DIV)
    ) u_clkgen (
        .i_clock (clock),
        .i_reset (reset),
        .i_en    (w_sck_en),
        .o_sck   (w_sck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        a_d     = a_q;
        d_d     = d_q;
        w_d     = 1'b0;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = done_q;
        last_d  = last_q;

        // Address advances in the cycle after each strobe.
        if (w_q) begin
            a_d = a_q + AW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CMD;
                    sh_d    = {C_CMD, BASE};
                    bit_d   = 5'd0;
                    a_d     = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end

            ST_CMD: begin
                if (w_fall) begin
                    sh_d = {sh_q[30:0], 1'b0};
                    if (bit_q == 5'd7) begin
                        bit_d   = 5'd0;
                        state_d = ST_ADDR;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

            ST_ADDR: begin
                if (w_fall) begin
                    sh_d = {sh_q[30:0], 1'b0};
                    if (bit_q == 5'd23) begin
                        bit_d   = 5'd0;
`ifdef ROM_LOADER_FAST_READ_EN
                        state_d = ST_DUMMY;
`else
                        state_d = ST_DATA;
`endif
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

`ifdef ROM_LOADER_FAST_READ_EN
            ST_DUMMY: begin
                // Eight clocks with MOSI low; MISO is ignored.
                if (w_fall) begin
                    if (bit_q == 5'd7) begin
                        bit_d   = 5'd0;
                        state_d = ST_DATA;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
`endif

            ST_DATA: begin
                if (w_rise) begin
                    rx_d = {rx_q[6:0], spiDi};
                end
                // A byte is complete when its 8th bit period ends.
                if (w_fall) begin
                    if (bit_q == 5'd7) begin
                        bit_d = 5'd0;
                        d_d   = rx_q;
                        w_d   = 1'b1;
                        if (a_q == C_LAST) begin
                            last_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
                if (last_q) begin
                    state_d = ST_DONE;
                    a_d     = '0;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sh_q    <= 32'd0;
            rx_q    <= 8'd0;
            bit_q   <= 5'd0;
            a_q     <= '0;
            d_q     <= 8'd0;
            w_q     <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            a_q     <= a_d;
            d_q     <= d_d;
            w_q     <= w_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    // MOSI carries the command/address MSB only while it is being sent.
    assign spiDo = ((state_q == ST_CMD) || (state_q == ST_ADDR)) ? sh_q[31] : 1'b0;
    assign spiCs = cs_q;
    assign spiCk = w_sck;
    assign a     = a_q;
    assign d     = d_q;
    assign w     = w_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_rom_loader
// Description : Self-checking bench for rom_loader. Two loaders (DIV=1 and
//               DIV=3) each talk to a behavioural SPI flash whose byte at
//               address x is x[7:0]^8'hA5. Expected writes are queued when a
//               load is started and popped by a monitor on every strobe.
// Build macro : ROM_LOADER_FAST_READ_EN selects the fast-read expectations.
// Revision    : 1.0 - initial release
//============================================================================
module tb_rom_loader;

    localparam int          KB     = 1;
    localparam int          NBYTES = KB * 1024;
    localparam logic [23:0] BASE   = 24'h010000;
`ifdef ROM_LOADER_FAST_READ_EN
    localparam int          HB      = 40;
    localparam logic [39:0] EXP_HDR = 40'h0B_0100_0000;
`else
    localparam int          HB      = 32;
    localparam logic [39:0] EXP_HDR = 40'h00_0301_0000;
`endif

    function automatic int first_w(input int div);
        return 1 + (HB + 8) * 2 * div;
    endfunction

    function automatic int done_cyc(input int div);
        return 2 + (HB + 8 * NBYTES) * 2 * div;
    endfunction

    function automatic logic [7:0] img_byte(input int i);
        logic [23:0] ad;
        ad = BASE + 24'(i);
        return ad[7:0] ^ 8'hA5;
    endfunction

    // Flash content for data bit idx after the header, from the address the
    // loader actually sent.
    function automatic logic flash_bit(input logic [39:0] h, input int idx);
        logic [23:0] ad;
        logic [7:0]  b;
`ifdef ROM_LOADER_FAST_READ_EN
        ad = h[31:8];
`else
        ad = h[23:0];
`endif
        ad = ad + 24'(idx / 8);
        b  = ad[7:0] ^ 8'hA5;
        return b[3'(7 - idx % 8)];
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n0 = 1'b0, rst_n1 = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       cs0, ck0, mo0, w0, busy0, done0;
    logic       cs1, ck1, mo1, w1, busy1, done1;
    logic       mi0 = 1'b0, mi1 = 1'b0;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;

    rom_loader #(.KB(KB), .BASE(BASE), .DIV(1)) u_dut0 (
        .clock(clk), .reset(rst_n0), .start(start0),
        .spiCs(cs0), .spiCk(ck0), .spiDo(mo0), .spiDi(mi0),
        .a(a0), .d(d0), .w(w0), .busy(busy0), .done(done0)
    );

    rom_loader #(.KB(KB), .BASE(BASE), .DIV(3)) u_dut1 (
        .clock(clk), .reset(rst_n1), .start(start1),
        .spiCs(cs1), .spiCk(ck1), .spiDo(mo1), .spiDi(mi1),
        .a(a1), .d(d1), .w(w1), .busy(busy1), .done(done1)
    );

    // ---------------- flash models ----------------
    int          fc0 = 0, fc1 = 0;
    logic [39:0] hdr0 = '0, hdr1 = '0;

    always @(negedge cs0 or posedge ck0) begin
        if (!cs0 && !ck0) begin
            fc0 = 0; hdr0 = '0;
        end else if (!cs0) begin
            if (fc0 < HB) hdr0 = {hdr0[38:0], mo0};
            fc0 = fc0 + 1;
        end
    end
    always @(negedge ck0) if (!cs0 && fc0 >= HB) mi0 = flash_bit(hdr0, fc0 - HB);

    always @(negedge cs1 or posedge ck1) begin
        if (!cs1 && !ck1) begin
            fc1 = 0; hdr1 = '0;
        end else if (!cs1) begin
            if (fc1 < HB) hdr1 = {hdr1[38:0], mo1};
            fc1 = fc1 + 1;
        end
    end
    always @(negedge ck1) if (!cs1 && fc1 >= HB) mi1 = flash_bit(hdr1, fc1 - HB);

    // ---------------- scoreboards / monitors ----------------
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] e0, e1;
    logic [7:0]  ram0 [NBYTES];
    logic [7:0]  ram1 [NBYTES];
    int acc0 = 0, seen0 = -1, last0 = 0, nst0 = 0;
    int acc1 = 0, seen1 = -1, last1 = 0, nst1 = 0;

    always @(negedge clk) begin
        if (w0) begin
            if (seen0 != acc0) begin
                seen0 = acc0;
                nst0  = 0;
                check("dut0_first_w_cycle", cyc - acc0, first_w(1));
                check("dut0_hdr_hi", {24'd0, hdr0[39:32]}, {24'd0, EXP_HDR[39:32]});
                check("dut0_hdr_lo", hdr0[31:0], EXP_HDR[31:0]);
            end else begin
                check("dut0_w_spacing", cyc - last0, 16);
            end
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL dut0_strobe: got a=%0d d=0x%0h, expected no write", a0, d0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_w_addr", {22'd0, a0}, {22'd0, e0[17:8]});
                check("dut0_w_data", {24'd0, d0}, {24'd0, e0[7:0]});
            end
            last0 = cyc;
            nst0++;
            ram0[a0] = d0;
        end
    end

    always @(negedge clk) begin
        if (w1) begin
            if (seen1 != acc1) begin
                seen1 = acc1;
                nst1  = 0;
                check("dut1_first_w_cycle", cyc - acc1, first_w(3));
                check("dut1_hdr_lo", hdr1[31:0], EXP_HDR[31:0]);
            end else begin
                check("dut1_w_spacing", cyc - last1, 48);
            end
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL dut1_strobe: got a=%0d d=0x%0h, expected no write", a1, d1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_w_addr", {22'd0, a1}, {22'd0, e1[17:8]});
                check("dut1_w_data", {24'd0, d1}, {24'd0, e1[7:0]});
            end
            last1 = cyc;
            nst1++;
            ram1[a1] = d1;
        end
    end

    // SCK half-period lengths on the DIV=3 loader.
    int   run1 = 0, viol1 = 0, tog1 = 0;
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        if (cs1) begin
            run1 = 0;
        end else if (run1 == 0) begin
            run1 = 1; prev1 = ck1;
        end else if (ck1 == prev1) begin
            run1++;
        end else begin
            if (run1 != 3) viol1++;
            tog1++;
            prev1 = ck1;
            run1  = 1;
        end
    end

    // Any SCK activity or chip select while reset is held.
    int rst_bad = 0;
    always @(negedge clk) if (!rst_n0 && (ck0 === 1'b1 || cs0 === 1'b0)) rst_bad++;

    // ---------------- stimulus ----------------
    task automatic start_dut0();
        @(negedge clk);
        start0 = 1'b1;
        acc0   = cyc;
        for (int i = 0; i < NBYTES; i++) q0.push_back({10'(i), img_byte(i)});
        @(negedge clk);
        start0 = 1'b0;
        check("dut0_accept_cs", {31'd0, cs0}, 0);
        check("dut0_accept_busy", {31'd0, busy0}, 1);
        check("dut0_accept_done", {31'd0, done0}, 0);
    endtask

    task automatic wait_done0();
        int n;
        int bad;
        n = 0;
        while (!done0 && n < 40000) begin @(negedge clk); n++; end
        check("dut0_done_seen", {31'd0, done0}, 1);
        check("dut0_done_cycle", cyc - acc0, done_cyc(1));
        check("dut0_done_busy", {31'd0, busy0}, 0);
        check("dut0_done_cs", {31'd0, cs0}, 1);
        check("dut0_done_ck", {31'd0, ck0}, 0);
        check("dut0_done_a_wrap", {22'd0, a0}, 0);
        check("dut0_strobe_count", nst0, NBYTES);
        check("dut0_queue_left", q0.size(), 0);
        bad = 0;
        for (int i = 0; i < NBYTES; i++) if (ram0[i] !== img_byte(i)) bad++;
        check("dut0_ram_readback_errors", bad, 0);
    endtask

    task automatic seq0();
        int n;
        // First load, with a spurious start in the middle of DATA.
        start_dut0();
        repeat (600) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("dut0_spurious_cs", {31'd0, cs0}, 0);
        check("dut0_spurious_busy", {31'd0, busy0}, 1);
        wait_done0();
        repeat (4) @(negedge clk);
        check("dut0_done_sticky", {31'd0, done0}, 1);

        // Reload from DONE, then reset after byte 100 is written.
        start_dut0();
        n = 0;
        do begin @(negedge clk); n++; end while (!(w0 && a0 == 10'd100) && n < 4000);
        check("dut0_byte100_seen", {31'd0, (w0 && a0 == 10'd100)}, 1);
        @(posedge clk);
        #1;
        rst_n0 = 1'b0;
        #1;
        check("dut0_rst_cs", {31'd0, cs0}, 1);
        check("dut0_rst_busy", {31'd0, busy0}, 0);
        check("dut0_rst_ck", {31'd0, ck0}, 0);
        check("dut0_rst_a", {22'd0, a0}, 0);
        check("dut0_rst_w", {31'd0, w0}, 0);
        q0.delete();
        @(negedge clk);
        rst_n0 = 1'b1;
        repeat (3) @(negedge clk);
        check("dut0_post_rst_idle_cs", {31'd0, cs0}, 1);
        start_dut0();
        wait_done0();
    endtask

    task automatic seq1();
        int n;
        int bad;
        @(negedge clk);
        start1 = 1'b1;
        acc1   = cyc;
        for (int i = 0; i < NBYTES; i++) q1.push_back({10'(i), img_byte(i)});
        @(negedge clk);
        start1 = 1'b0;
        check("dut1_accept_cs", {31'd0, cs1}, 0);
        check("dut1_accept_busy", {31'd0, busy1}, 1);
        n = 0;
        while (!done1 && n < 60000) begin @(negedge clk); n++; end
        check("dut1_done_seen", {31'd0, done1}, 1);
        check("dut1_done_cycle", cyc - acc1, done_cyc(3));
        check("dut1_done_cs", {31'd0, cs1}, 1);
        check("dut1_strobe_count", nst1, NBYTES);
        check("dut1_sck_halfperiod_errors", viol1, 0);
        check("dut1_sck_toggles", tog1, 2 * (HB + 8 * NBYTES));
        bad = 0;
        for (int i = 0; i < NBYTES; i++) if (ram1[i] !== img_byte(i)) bad++;
        check("dut1_ram_readback_errors", bad, 0);
    endtask

    initial begin
        // Reset held for 5 cycles with a start pulse inside it.
        repeat (2) @(negedge clk);
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cs", {31'd0, cs0}, 1);
        check("rst_ck", {31'd0, ck0}, 0);
        check("rst_do", {31'd0, mo0}, 0);
        check("rst_a", {22'd0, a0}, 0);
        check("rst_d", {24'd0, d0}, 0);
        check("rst_w", {31'd0, w0}, 0);
        check("rst_busy", {31'd0, busy0}, 0);
        check("rst_done", {31'd0, done0}, 0);
        check("rst_dut1_cs", {31'd0, cs1}, 1);
        check("rst_sck_activity", rst_bad, 0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst_cs", {31'd0, cs0}, 1);
        check("idle_after_rst_busy", {31'd0, busy0}, 0);
        fork
            seq0();
            seq1();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got cycle %0d, expected completion earlier", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
